// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- small sequential ALU with a valid/ready handshake on both sides.
//
// Most operations finish one cycle after they are accepted. The extended AND
// (ext=1) is an unsigned multiply, done as shift-add over WIDTH cycles when
// MUL_EN=1. When MUL_EN=0 it behaves as a plain AND.
//
// Parameters
//   WIDTH   datapath width of accum/data/out (4..32)
//   MUL_EN  1 = iterative multiplier present, 0 = ext+AND is plain AND
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   accum      accumulator operand
//   data       memory/data operand
//   opcode     HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   ext        ADD+ext = SUB, AND+ext = MUL; ignored for other opcodes
//   in_valid   request valid
//   in_ready   block can accept a request this cycle
//   out        registered result
//   out_valid  out and flags are valid
//   out_ready  consumer takes the result
//   zero       combinational (accum == 0)
//   carry      carry/borrow of ADD/SUB; high half nonzero for MUL
//   ovf        signed overflow of ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       opcode,
    input  logic             ext,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic                 is_mul;
    logic [WIDTH-1:0]     res;
    logic                 res_carry;
    logic                 res_ovf;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [WIDTH:0]       partial;
    logic [2*WIDTH-1:0]   prod_step;

    // Held low during reset so nothing is offered as accepted while rst_n=0.
    assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = (accum == '0);

    // Single-cycle result straight from the request inputs; it is only
    // registered on accept, so later input changes cannot disturb it.
    always_comb begin
        res       = accum;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        is_mul    = 1'b0;
        sum_ext   = {1'b0, accum} + {1'b0, data};
        diff_ext  = {1'b0, accum} - {1'b0, data};
        case (opcode)
            OP_ADD: begin
                if (ext) begin
                    // Top bit of the widened difference is the unsigned borrow.
                    res       = diff_ext[WIDTH-1:0];
                    res_carry = diff_ext[WIDTH];
                    res_ovf   = (accum[WIDTH-1] != data[WIDTH-1]) &&
                                (diff_ext[WIDTH-1] != accum[WIDTH-1]);
                end else begin
                    res       = sum_ext[WIDTH-1:0];
                    res_carry = sum_ext[WIDTH];
                    res_ovf   = (accum[WIDTH-1] == data[WIDTH-1]) &&
                                (sum_ext[WIDTH-1] != accum[WIDTH-1]);
                end
            end
            OP_AND: begin
                if (ext && MUL_EN) is_mul = 1'b1;
                else               res    = accum & data;
            end
            OP_XOR: res = accum ^ data;
            OP_LDA: res = data;
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: res = accum;
            default: res = accum;
        endcase
    end

    // One shift-add step: prod_q holds {partial high half, remaining
    // multiplier bits}; the LSB picks whether the multiplicand is added.
    always_comb begin
        partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_step = {partial, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (is_mul) begin
                state_d = BUSY;
                mcand_d = accum;
                prod_d  = {{WIDTH{1'b0}}, data};
                cnt_d   = '0;
            end else begin
                state_d = DONE;
                out_d   = res;
                carry_d = res_carry;
                ovf_d   = res_ovf;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    prod_d = prod_step;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        out_d   = prod_step[WIDTH-1:0];
                        carry_d = |prod_step[2*WIDTH-1:WIDTH];
                        ovf_d   = 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] accum, data;
    logic [2:0] opcode;
    logic       ext, in_valid, out_ready;
    logic       in_ready, out_valid, zero, carry, ovf;
    logic [7:0] out;

    // second instance without multiplier
    logic [7:0] accum0, data0;
    logic [2:0] opcode0;
    logic       ext0, in_valid0, out_ready0;
    logic       in_ready0, out_valid0, zero0, carry0, ovf0;
    logic [7:0] out0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .accum(accum), .data(data), .opcode(opcode),
        .ext(ext), .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .out_ready(out_ready), .zero(zero),
        .carry(carry), .ovf(ovf)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .accum(accum0), .data(data0), .opcode(opcode0),
        .ext(ext0), .in_valid(in_valid0), .in_ready(in_ready0), .out(out0),
        .out_valid(out_valid0), .out_ready(out_ready0), .zero(zero0),
        .carry(carry0), .ovf(ovf0)
    );

    typedef struct {
        logic [2:0] op;
        logic       e;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       o;
        int         lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic rules, WIDTH=8.
    function automatic void model(input int op, input int e, input int a, input int b,
                                  input int mul_en, output int r, output int c,
                                  output int o, output int lat);
        int sa, sb, t;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = a; c = 0; o = 0; lat = 1;
        case (op)
            2: begin
                if (e != 0) begin
                    t = a - b;
                    r = (t + 256) % 256;
                    c = (a < b) ? 1 : 0;
                    o = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
                end else begin
                    t = a + b;
                    r = t % 256;
                    c = (t > 255) ? 1 : 0;
                    o = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
                end
            end
            3: begin
                if (e != 0 && mul_en != 0) begin
                    t = a * b;
                    r = t % 256;
                    c = (t > 255) ? 1 : 0;
                    lat = 9;
                end else begin
                    r = a & b;
                end
            end
            4: r = a ^ b;
            5: r = b;
            default: r = a;
        endcase
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE and out_ready=1.
    // Returns at the negedge where out_valid is first seen.
    task automatic run_op(input logic [2:0] op, input logic e, input logic [7:0] a,
                          input logic [7:0] b, output int r, output int c,
                          output int o, output int lat);
        opcode = op; ext = e; accum = a; data = b;
        in_valid = 1'b1; out_ready = 1'b1;
        chk("in_ready_offer", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        accum = 8'($urandom); data = 8'($urandom);
        opcode = 3'($urandom); ext = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: out_valid not seen within %0d cycles (op=%0d ext=%0d)", lat, op, e);
        end
        r = int'(out); c = int'(carry); o = int'(ovf);
        $display("op=%0d ext=%0d a=%02h b=%02h -> out=%02h carry=%0d ovf=%0d lat=%0d",
                 op, e, a, b, out, carry, ovf, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, o, lat, er, ec, eo, elat;
        logic [2:0] rop;
        logic       re;
        logic [7:0] ra, rb;

        vecs[0]  = '{3'd2, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1};
        vecs[1]  = '{3'd2, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1};
        vecs[2]  = '{3'd3, 1'b1, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 9};
        vecs[3]  = '{3'd2, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1};
        vecs[4]  = '{3'd2, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1};
        vecs[5]  = '{3'd3, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'd4, 1'b0, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'd5, 1'b0, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'd0, 1'b0, 8'h33, 8'h44, 8'h33, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'd1, 1'b0, 8'h00, 8'h77, 8'h00, 1'b0, 1'b0, 1};
        vecs[10] = '{3'd6, 1'b0, 8'h9C, 8'h01, 8'h9C, 1'b0, 1'b0, 1};
        vecs[11] = '{3'd7, 1'b0, 8'h12, 8'hFF, 8'h12, 1'b0, 1'b0, 1};
        vecs[12] = '{3'd3, 1'b1, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 9};
        vecs[13] = '{3'd3, 1'b1, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 9};
        vecs[14] = '{3'd2, 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1};
        vecs[15] = '{3'd2, 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1};
        vecs[16] = '{3'd4, 1'b1, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1};
        vecs[17] = '{3'd3, 1'b1, 8'h00, 8'hAB, 8'h00, 1'b0, 1'b0, 9};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        accum = 8'h00; data = 8'h01; opcode = 3'd2; ext = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        accum0 = 8'h00; data0 = 8'h00; opcode0 = 3'd0; ext0 = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_zero_on", 32'(zero), 32'd1);
        accum = 8'h05;
        #1;
        chk("rst_zero_off", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].e, vecs[i].a, vecs[i].b, r, c, o, lat);
            chk($sformatf("vec%0d_out", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].c));
            chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].o));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // ---------------- back-pressure ----------------
        opcode = 3'd4; ext = 1'b0; accum = 8'hAA; data = 8'h0F;
        in_valid = 1'b1; out_ready = 1'b1;
        chk("bp_offer_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        opcode = 3'd5; accum = 8'h00; data = 8'h3C; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_hold%0d_out", k), 32'(out), 32'hA5);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        $display("backpressure: XOR held out=%02h for 5 cycles", out);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_lda_out", 32'(out), 32'h3C);
        chk("bp_lda_valid", 32'(out_valid), 32'd1);
        $display("backpressure: LDA back-to-back out=%02h", out);

        // ---------------- reset in the middle of a multiply ----------------
        run_op(3'd2, 1'b0, 8'hF0, 8'h20, r, c, o, lat);
        chk("pre_mul_carry", 32'(c), 32'd1);
        opcode = 3'd3; ext = 1'b1; accum = 8'h10; data = 8'h11; in_valid = 1'b1;
        @(negedge clk);           // BUSY cycle 1
        in_valid = 1'b0;
        @(negedge clk);           // BUSY cycle 2
        @(negedge clk);           // BUSY cycle 3
        chk("mul_busy3_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_idle", 32'(in_ready), 32'd1);
        $display("reset mid-MUL: out=%02h out_valid=%0d", out, out_valid);
        run_op(3'd2, 1'b0, 8'h01, 8'h01, r, c, o, lat);
        chk("midrst_add_out", 32'(r), 32'h02);
        chk("midrst_add_lat", 32'(lat), 32'd1);
        @(negedge clk);
        repeat (12) @(negedge clk);
        chk("idle_valid_low", 32'(out_valid), 32'd0);
        chk("idle_out_kept", 32'(out), 32'h02);

        // ---------------- zero flag ----------------
        for (int k = 0; k < 6; k++) begin
            accum = (k % 2 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            #1;
            chk($sformatf("zero%0d", k), 32'(zero), (accum == 8'h00) ? 32'd1 : 32'd0);
        end
        @(negedge clk);

        // ---------------- random vs model ----------------
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            re  = 1'($urandom_range(0, 1));
            ra  = (i % 8 == 0) ? 8'h00 : 8'($urandom);
            rb  = 8'($urandom);
            model(int'(rop), int'(re), int'(ra), int'(rb), 1, er, ec, eo, elat);
            run_op(rop, re, ra, rb, r, c, o, lat);
            chk($sformatf("rnd%0d_out", i), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_carry", i), 32'(c), 32'(ec));
            chk($sformatf("rnd%0d_ovf", i), 32'(o), 32'(eo));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
        end

        // ---------------- MUL_EN=0 instance ----------------
        accum0 = 8'h00; in_valid0 = 1'b0;
        #1;
        chk("nomul_zero", 32'(zero0), 32'd1);
        @(negedge clk);
        opcode0 = 3'd3; ext0 = 1'b1; accum0 = 8'hCC; data0 = 8'h0F;
        in_valid0 = 1'b1; out_ready0 = 1'b1;
        chk("nomul_ready", 32'(in_ready0), 32'd1);
        @(negedge clk);
        in_valid0 = 1'b0;
        chk("nomul_valid", 32'(out_valid0), 32'd1);
        chk("nomul_out", 32'(out0), 32'h0C);
        chk("nomul_carry", 32'(carry0), 32'd0);
        $display("MUL_EN=0: AND ext=1 CC&0F -> out=%02h", out0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
